// File: rtl/amdc_ecs_trigger_sched.sv
// amdc_ecs_trigger_sched: schedules ADC conversions from PWM carrier peak/valley
// pulses or a software trigger, with decimation, and collects the SPI results.
// Each accepted event becomes a one-cycle spi_trigger pulse in the following cycle.
// An event that arrives while a conversion is in flight, or while the SPI master
// reports busy, is dropped and counted in overrun_cnt.
// Ports:
//   clk, rst            : clock and asynchronous active-high reset
//   en, trig_sel        : master enable and per-carrier event enables
//   carrier_high/low    : carrier peak/valley pulses
//   sw_trig             : software trigger pulse
//   decim               : a conversion is issued on every (decim+1)th eligible event
//   spi_trigger         : start pulse to the SPI master
//   spi_done            : SPI master done level (low while busy)
//   spi_data_x/y        : SPI master result registers
//   data_x/y, data_valid: last good sample and its one-cycle update strobe
//   sample_cnt          : completed samples (wraps)
//   overrun_cnt         : dropped events (saturates)
//   timeout, timeout_clr: sticky wait-abort flag and its clear
//   busy                : high whenever a conversion is in flight
module amdc_ecs_trigger_sched #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  trig_sel,
  input  logic        carrier_high,
  input  logic        carrier_low,
  input  logic        sw_trig,
  input  logic [7:0]  decim,
  output logic        spi_trigger,
  input  logic        spi_done,
  input  logic [17:0] spi_data_x,
  input  logic [17:0] spi_data_y,
  output logic [17:0] data_x,
  output logic [17:0] data_y,
  output logic        data_valid,
  output logic [15:0] sample_cnt,
  output logic [15:0] overrun_cnt,
  output logic        timeout,
  input  logic        timeout_clr,
  output logic        busy
);

  // The timer only needs to count up to TIMEOUT_CYCLES-1.
  localparam int            TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_LATCH
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_dec_cnt;
  logic [TW-1:0] r_timer;
  logic          r_spi_trigger;
  logic [17:0]   r_data_x;
  logic [17:0]   r_data_y;
  logic          r_data_valid;
  logic [15:0]   r_sample_cnt;
  logic [15:0]   r_overrun_cnt;
  logic          r_timeout;

  logic w_evt;
  logic w_take;
  logic w_fire;
  logic w_overrun;
  logic w_wait_exp;
  logic w_tmo;

  // Simultaneous sources collapse into a single event.
  assign w_evt = en & ((carrier_high & trig_sel[0]) |
                       (carrier_low  & trig_sel[1]) |
                       sw_trig);

  // Events are only usable in IDLE with the SPI master ready; anything else is dropped.
  assign w_take    = w_evt & (r_state == S_IDLE) & spi_done;
  assign w_overrun = w_evt & ~((r_state == S_IDLE) & spi_done);

  // '>=' rather than '==' so that lowering decim below the running count
  // issues on the next event instead of waiting for the 8-bit counter to wrap.
  assign w_fire     = w_take & (r_dec_cnt >= decim);
  assign w_wait_exp = (r_timer == TLAST);

  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!spi_done) begin
          w_next = S_WAIT_DONE;
        end else if (w_wait_exp) begin
          w_next = S_IDLE;
          w_tmo  = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (spi_done) begin
          w_next = S_LATCH;
        end else if (w_wait_exp) begin
          w_next = S_IDLE;
          w_tmo  = 1'b1;
        end
      end
      S_LATCH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait timer: any state change (including entry to either wait state) restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_next != r_state) begin
      r_timer <= '0;
    end else if ((r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE)) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec_cnt <= 8'd0;
    end else if (w_take) begin
      r_dec_cnt <= w_fire ? 8'd0 : (r_dec_cnt + 8'd1);
    end
  end

  // Strobes are registered on entry so they are high exactly while the FSM
  // sits in ISSUE / LATCH, and the captured data is visible with data_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spi_trigger <= 1'b0;
      r_data_valid  <= 1'b0;
      r_data_x      <= 18'd0;
      r_data_y      <= 18'd0;
      r_sample_cnt  <= 16'd0;
    end else begin
      r_spi_trigger <= (w_next == S_ISSUE);
      r_data_valid  <= (w_next == S_LATCH);
      if (w_next == S_LATCH) begin
        r_data_x     <= spi_data_x;
        r_data_y     <= spi_data_y;
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun_cnt <= 16'd0;
    end else if (w_overrun && (r_overrun_cnt != 16'hFFFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end
  end

  // A new abort outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_tmo) begin
      r_timeout <= 1'b1;
    end else if (timeout_clr) begin
      r_timeout <= 1'b0;
    end
  end

  assign spi_trigger = r_spi_trigger;
  assign data_x      = r_data_x;
  assign data_y      = r_data_y;
  assign data_valid  = r_data_valid;
  assign sample_cnt  = r_sample_cnt;
  assign overrun_cnt = r_overrun_cnt;
  assign timeout     = r_timeout;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_amdc_ecs_trigger_sched.sv
// Testbench for amdc_ecs_trigger_sched. A timeline model predicts, from each
// accepted trigger and its conversion length, the trigger pulse, busy window,
// data_valid strobe and counter values. A second instance with a short timeout
// covers the abort behaviour.
module tb_amdc_ecs_trigger_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en;
  logic [1:0]  trig_sel;
  logic        carrier_high;
  logic        carrier_low;
  logic        sw_trig;
  logic [7:0]  decim;
  logic        spi_done;
  logic [17:0] spi_data_x;
  logic [17:0] spi_data_y;
  logic        timeout_clr;

  logic        spi_trigger, data_valid, timeout, busy;
  logic [17:0] data_x, data_y;
  logic [15:0] sample_cnt, overrun_cnt;

  logic        t_spi_trigger, t_data_valid, t_timeout, t_busy;
  logic [17:0] t_data_x, t_data_y;
  logic [15:0] t_sample_cnt, t_overrun_cnt;

  amdc_ecs_trigger_sched #(.TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .rst(rst), .en(en), .trig_sel(trig_sel),
    .carrier_high(carrier_high), .carrier_low(carrier_low), .sw_trig(sw_trig),
    .decim(decim), .spi_trigger(spi_trigger), .spi_done(spi_done),
    .spi_data_x(spi_data_x), .spi_data_y(spi_data_y),
    .data_x(data_x), .data_y(data_y), .data_valid(data_valid),
    .sample_cnt(sample_cnt), .overrun_cnt(overrun_cnt),
    .timeout(timeout), .timeout_clr(timeout_clr), .busy(busy)
  );

  amdc_ecs_trigger_sched #(.TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .rst(rst), .en(en), .trig_sel(trig_sel),
    .carrier_high(carrier_high), .carrier_low(carrier_low), .sw_trig(sw_trig),
    .decim(decim), .spi_trigger(t_spi_trigger), .spi_done(spi_done),
    .spi_data_x(spi_data_x), .spi_data_y(spi_data_y),
    .data_x(t_data_x), .data_y(t_data_y), .data_valid(t_data_valid),
    .sample_cnt(t_sample_cnt), .overrun_cnt(t_overrun_cnt),
    .timeout(t_timeout), .timeout_clr(timeout_clr), .busy(t_busy)
  );

  always #5 clk = ~clk;

  int n_assert;
  int n_fail;
  int cyc;

  // Reference model: one transaction described by its trigger cycle and length.
  int          m_trig, m_end, m_L, m_dec;
  logic [15:0] m_ovr, m_scnt;
  logic [17:0] m_x, m_y, m_dx, m_dy;
  int          nxt_L;
  logic [17:0] nxt_x, nxt_y;
  bit          spi_auto, man_done, hold_low, chk_on;
  int          cnt_trig, cnt_dv, t_cnt_dv, base_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the SPI response, advance the model across the edge, then check.
  task automatic tick();
    logic done_v;
    logic ev;
    if (spi_auto) done_v = !((cyc >= m_trig + 1) && (cyc <= m_trig + m_L)) && !hold_low;
    else          done_v = man_done;
    spi_done   = done_v;
    spi_data_x = m_x;
    spi_data_y = m_y;
    ev = en & ((carrier_high & trig_sel[0]) | (carrier_low & trig_sel[1]) | sw_trig);
    @(posedge clk);
    cyc++;
    if (ev) begin
      if (((cyc - 1 >= m_trig) && (cyc - 1 <= m_end)) || !done_v) begin
        if (m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
      end else if (m_dec >= int'(decim)) begin
        m_dec  = 0;
        m_trig = cyc;
        m_L    = nxt_L;
        m_end  = cyc + nxt_L + 2;
        m_x    = nxt_x;
        m_y    = nxt_y;
      end else begin
        m_dec++;
      end
    end
    if (cyc == m_end) begin
      m_dx   = m_x;
      m_dy   = m_y;
      m_scnt = m_scnt + 16'd1;
    end
    #1;
    carrier_high = 1'b0;
    carrier_low  = 1'b0;
    sw_trig      = 1'b0;
    timeout_clr  = 1'b0;
    if (spi_trigger)  cnt_trig++;
    if (data_valid)   cnt_dv++;
    if (t_data_valid) t_cnt_dv++;
    if (chk_on) begin
      chk("cyc_trigger", 32'(spi_trigger), 32'(cyc == m_trig));
      chk("cyc_data_valid", 32'(data_valid), 32'(cyc == m_end));
      chk("cyc_busy", 32'(busy), 32'((cyc >= m_trig) && (cyc <= m_end)));
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_sample_cnt"}, 32'(sample_cnt), 32'(m_scnt));
    chk({tag, "_overrun_cnt"}, 32'(overrun_cnt), 32'(m_ovr));
    chk({tag, "_data_x"}, 32'(data_x), 32'(m_dx));
    chk({tag, "_data_y"}, 32'(data_y), 32'(m_dy));
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_spi_trigger", 32'(spi_trigger), 32'd0);
    chk("rst_data_x", 32'(data_x), 32'd0);
    chk("rst_data_y", 32'(data_y), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_overrun_cnt", 32'(overrun_cnt), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_t_busy", 32'(t_busy), 32'd0);
    chk("rst_t_timeout", 32'(t_timeout), 32'd0);
    m_trig = -100; m_end = -100; m_L = 0; m_dec = 0;
    m_ovr = 16'd0; m_scnt = 16'd0; m_dx = 18'd0; m_dy = 18'd0;
    cnt_trig = 0; cnt_dv = 0; t_cnt_dv = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0;
    en = 1'b0; trig_sel = 2'b00; carrier_high = 1'b0; carrier_low = 1'b0;
    sw_trig = 1'b0; decim = 8'd0; spi_done = 1'b1; spi_data_x = 18'd0;
    spi_data_y = 18'd0; timeout_clr = 1'b0;
    spi_auto = 1'b1; man_done = 1'b1; hold_low = 1'b0; chk_on = 1'b1;
    nxt_L = 10; nxt_x = 18'd0; nxt_y = 18'd0; m_x = 18'd0; m_y = 18'd0;
    #3;
    do_reset();

    // Basic sample: single carrier_high, 200-cycle conversion.
    en = 1'b1; trig_sel = 2'b01; decim = 8'd0;
    nxt_L = 200; nxt_x = 18'h2AAAA; nxt_y = 18'h15555;
    carrier_high = 1'b1;
    tick();
    repeat (210) tick();
    chk("basic_trig_count", 32'(cnt_trig), 32'd1);
    chk("basic_dv_count", 32'(cnt_dv), 32'd1);
    chk("basic_data_x", 32'(data_x), 32'h2AAAA);
    chk("basic_data_y", 32'(data_y), 32'h15555);
    chk("basic_sample_cnt", 32'(sample_cnt), 32'd1);
    check_model("basic");

    // Decimation by 4: triggers on the 4th and 8th events only.
    decim = 8'd3; nxt_L = 10; base_t = cnt_trig;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) carrier_high = 1'b1;
      else            sw_trig = 1'b1;
      tick();
      chk("decim_trigger_on_event", 32'(spi_trigger), 32'((i == 3) || (i == 7)));
      repeat (20) tick();
    end
    chk("decim_trig_total", 32'(cnt_trig - base_t), 32'd2);
    check_model("decim");

    // Overrun: second carrier_low during WAIT_DONE, then an event while spi_done is low in IDLE.
    decim = 8'd0; trig_sel = 2'b10; nxt_L = 50; base_t = cnt_trig;
    carrier_low = 1'b1;
    tick();
    repeat (10) tick();
    chk("ovr_busy_mid", 32'(busy), 32'd1);
    carrier_low = 1'b1;
    tick();
    repeat (60) tick();
    chk("ovr_cnt_first", 32'(overrun_cnt), 32'd1);
    chk("ovr_trig_first", 32'(cnt_trig - base_t), 32'd1);
    hold_low = 1'b1;
    tick();
    carrier_low = 1'b1;
    tick();
    tick();
    hold_low = 1'b0;
    tick();
    chk("ovr_cnt_second", 32'(overrun_cnt), 32'd2);
    chk("ovr_trig_second", 32'(cnt_trig - base_t), 32'd1);
    check_model("ovr");

    // Reset while in WAIT_DONE, then a normal sample.
    trig_sel = 2'b00; nxt_L = 100; nxt_x = 18'h30F0F; nxt_y = 18'h01234;
    sw_trig = 1'b1;
    tick();
    repeat (20) tick();
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    do_reset();
    repeat (120) tick();
    chk("rstmid_no_dv", 32'(cnt_dv), 32'd0);
    nxt_L = 20; nxt_x = 18'h1ABCD; nxt_y = 18'h2DCBA;
    sw_trig = 1'b1;
    tick();
    repeat (30) tick();
    chk("rstmid_dv_after", 32'(cnt_dv), 32'd1);
    chk("rstmid_data_x", 32'(data_x), 32'h1ABCD);
    chk("rstmid_data_y", 32'(data_y), 32'h2DCBA);
    chk("rstmid_sample_cnt", 32'(sample_cnt), 32'd1);

    // Saturation of overrun_cnt and wrap of sample_cnt.
    force dut.r_overrun_cnt = 16'hFFFF;
    #1;
    release dut.r_overrun_cnt;
    m_ovr = 16'hFFFF;
    hold_low = 1'b1;
    tick();
    sw_trig = 1'b1;
    tick();
    tick();
    hold_low = 1'b0;
    tick();
    chk("ovr_saturate", 32'(overrun_cnt), 32'hFFFF);
    force dut.r_sample_cnt = 16'hFFFF;
    #1;
    release dut.r_sample_cnt;
    m_scnt = 16'hFFFF;
    nxt_L = 5;
    sw_trig = 1'b1;
    tick();
    repeat (12) tick();
    chk("sample_wrap", 32'(sample_cnt), 32'd0);
    check_model("satwrap");

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en           = ($urandom_range(0, 9) != 0);
      trig_sel     = 2'($urandom_range(0, 3));
      carrier_high = ($urandom_range(0, 29) == 0);
      carrier_low  = ($urandom_range(0, 29) == 0);
      sw_trig      = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 199) == 0) decim = 8'($urandom_range(0, 3));
      if (cyc > m_end) hold_low = ($urandom_range(0, 15) == 0);
      nxt_L = int'($urandom_range(1, 40));
      nxt_x = 18'($urandom);
      nxt_y = 18'($urandom);
      tick();
      if (data_valid) begin
        chk("rnd_data_x", 32'(data_x), 32'(m_dx));
        chk("rnd_data_y", 32'(data_y), 32'(m_dy));
      end
    end
    hold_low = 1'b0; en = 1'b0;
    repeat (50) tick();
    check_model("rnd");

    // Timeout on the short-timeout instance: spi_done never falls.
    do_reset();
    chk_on = 1'b0; spi_auto = 1'b0; man_done = 1'b1;
    en = 1'b1; decim = 8'd0;
    sw_trig = 1'b1;
    tick();
    chk("to_trigger", 32'(t_spi_trigger), 32'd1);
    repeat (16) tick();
    chk("to_busy_before", 32'(t_busy), 32'd1);
    chk("to_flag_before", 32'(t_timeout), 32'd0);
    tick();
    chk("to_flag_set", 32'(t_timeout), 32'd1);
    chk("to_back_idle", 32'(t_busy), 32'd0);
    chk("to_no_dv", 32'(t_cnt_dv), 32'd0);
    chk("to_sample_cnt", 32'(t_sample_cnt), 32'd0);
    chk("to_data_x", 32'(t_data_x), 32'd0);
    chk("to_data_y", 32'(t_data_y), 32'd0);
    chk("to_overrun_cnt", 32'(t_overrun_cnt), 32'd0);
    timeout_clr = 1'b1;
    tick();
    chk("to_clear", 32'(t_timeout), 32'd0);
    sw_trig = 1'b1;
    tick();
    repeat (16) tick();
    timeout_clr = 1'b1;
    tick();
    chk("to_set_wins", 32'(t_timeout), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
